// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streamer.
// Holds the output-buffer state encoding and the default widths used by
// fifo_rd_streamer and fifo_skid_buf.
package fifo_pkg;

  // Buffer occupancy state; the encoding equals the number of held words.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer (head/tail) feeding a valid/ready stream.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   flush           drop all buffered words at the next edge
//   push, push_data word captured from the FIFO read path this cycle
//   ready           downstream ready
//   valid, data     registered stream outputs (data is the head entry)
//   occ             current occupancy (0..2)
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | no word held, valid low
// ST_ONE   | head holds the next word to present
// ST_TWO   | head presented, tail holds the following word
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            occ
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  valid_q, valid_d;
  logic                  pop;

  assign pop = valid_q & ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({push, pop})
          2'b11: head_d = push_data;
          2'b10: begin
            tail_d  = push_data;
            state_d = ST_TWO;
          end
          2'b01: state_d = ST_EMPTY;
          default: ;
        endcase
      end
      ST_TWO: begin
        // A push without a pop cannot arrive here: the issue logic never
        // lets occupancy plus the in-flight read exceed two.
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
          if (push) begin
            tail_d  = push_data;
            state_d = ST_TWO;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign data  = head_q;
  assign occ   = state_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side consumer for the async FIFO, running in the read clock domain.
// Issues FIFO reads, absorbs the one-cycle registered read latency in a
// two-entry buffer and presents the words as a valid/ready stream.
// Ports:
//   rclk, r_rstn  read clock, synchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_re       FIFO read enable (combinational)
//   fifo_rdata    FIFO data, valid the cycle after an accepted read
//   m_valid, m_ready, m_data  output stream
//   flush         discard buffered and in-flight words
//   xfer_cnt      wrapping count of stream transfers (not cleared by flush)
//   busy          a word is buffered or in flight
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  rclk,
  input  logic                  r_rstn,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  busy
);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic                 pop;
  logic                 capture;
  logic [1:0]           occ;
  logic [2:0]           pending;

  assign pop = m_valid & m_ready;

  // Slots committed after this edge. Counting the pop here (a combinational
  // path from m_ready) lets a full buffer issue a read in the same cycle it
  // drains, which is what sustains one word per cycle.
  assign pending = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  assign fifo_re = r_rstn & ~flush & ~fifo_empty & (pending < 3'd2);

  // A word arriving during a flush belongs to the discarded stream.
  assign capture = inflight_q & ~flush;

  always_comb begin
    inflight_d = fifo_re;
    xfer_cnt_d = xfer_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
  end

  always_ff @(posedge rclk) begin
    if (!r_rstn) begin
      inflight_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (rclk),
    .rst_n     (r_rstn),
    .flush     (flush),
    .push      (capture),
    .push_data (fifo_rdata),
    .ready     (m_ready),
    .valid     (m_valid),
    .data      (m_data),
    .occ       (occ)
  );

  assign xfer_cnt = xfer_cnt_q;
  assign busy     = (occ != 2'd0) | inflight_q;

endmodule
